// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer driving a shared 32-bit ALU.
// One shift-add or restoring-divide step per cycle into HI/LO.
module muldiv_sequencer #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam logic [3:0]     ALU_ADD = 4'd2;
    localparam logic [3:0]     ALU_SUB = 4'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEG_A,
        S_NEG_B,
        S_ITER,
        S_FIX_LO,
        S_FIX_HI,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  w_q, w_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              div_q, div_d;
    logic              sgn_q, sgn_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic              lo_zero_q, lo_zero_d;

    logic [WIDTH-1:0]  sh;
    logic              carry;
    logic              qbit;
    logic              flip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            w_q       <= '0;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            sgn_q     <= 1'b0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            lo_zero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            w_q       <= w_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            sgn_q     <= sgn_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            lo_zero_q <= lo_zero_d;
        end
    end

    // lo holds the multiplier / dividend, w the multiplicand / divisor
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        w_d       = w_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        sgn_d     = sgn_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        lo_zero_d = lo_zero_q;
        alu_op    = ALU_ADD;
        alu_a     = '0;
        alu_b     = '0;
        busy      = 1'b0;
        done      = 1'b0;
        sh        = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        carry     = 1'b0;
        qbit      = 1'b0;
        flip      = neg_a_q ^ neg_b_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    div_d     = op[1];
                    sgn_d     = ~op[0];
                    neg_a_d   = ~op[0] & a[WIDTH-1];
                    neg_b_d   = ~op[0] & b[WIDTH-1];
                    cnt_d     = '0;
                    lo_zero_d = 1'b0;
                    w_d       = op[1] ? b : a;
                    if (op[1] && (b == '0)) begin
                        hi_d    = a;
                        lo_d    = DIV0_LO;
                        state_d = S_DONE;
                    end else begin
                        hi_d    = '0;
                        lo_d    = op[1] ? a : b;
                        state_d = op[0] ? S_ITER : S_NEG_A;
                    end
                end
            end
            S_NEG_A: begin
                busy   = 1'b1;
                alu_op = ALU_SUB;
                alu_b  = div_q ? lo_q : w_q;
                if (neg_a_q) begin
                    if (div_q) lo_d = alu_result;
                    else       w_d  = alu_result;
                end
                state_d = S_NEG_B;
            end
            S_NEG_B: begin
                busy   = 1'b1;
                alu_op = ALU_SUB;
                alu_b  = div_q ? w_q : lo_q;
                if (neg_b_q) begin
                    if (div_q) w_d  = alu_result;
                    else       lo_d = alu_result;
                end
                state_d = S_ITER;
            end
            S_ITER: begin
                busy  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (div_q) begin
                    alu_op = ALU_SUB;
                    alu_a  = sh;
                    alu_b  = w_q;
                    // hi[MSB] set means the shifted remainder has 33 bits
                    if (hi_q[WIDTH-1] || (sh >= w_q)) begin
                        hi_d = alu_result;
                        qbit = 1'b1;
                    end else begin
                        hi_d = sh;
                    end
                    lo_d = {lo_q[WIDTH-2:0], qbit};
                end else begin
                    alu_op = ALU_ADD;
                    alu_a  = hi_q;
                    alu_b  = lo_q[0] ? w_q : '0;
                    carry  = (alu_result < hi_q);
                    hi_d   = {carry, alu_result[WIDTH-1:1]};
                    lo_d   = {alu_result[0], lo_q[WIDTH-1:1]};
                end
                if (cnt_q == LAST) begin
                    state_d = sgn_q ? S_FIX_LO : S_DONE;
                end
            end
            S_FIX_LO: begin
                busy      = 1'b1;
                alu_op    = ALU_SUB;
                alu_b     = lo_q;
                lo_zero_d = (lo_q == '0);
                if (flip) lo_d = alu_result;
                state_d = S_FIX_HI;
            end
            S_FIX_HI: begin
                busy   = 1'b1;
                alu_op = ALU_SUB;
                alu_b  = hi_q;
                if (div_q) begin
                    if (neg_a_q) hi_d = alu_result;
                end else if (flip) begin
                    // borrow into hi only when the low word negated to zero
                    hi_d = lo_zero_q ? alu_result : ~hi_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed table, corner
// sequences and random ops against an arithmetic reference model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result)
    );

    always_comb begin
        case (alu_op)
            4'd0:    alu_result = alu_a & alu_b;
            4'd1:    alu_result = alu_a | alu_b;
            4'd2:    alu_result = alu_a + alu_b;
            4'd3:    alu_result = alu_a - alu_b;
            4'd4:    alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
            4'd5:    alu_result = alu_a ^ alu_b;
            default: alu_result = 32'h0;
        endcase
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o,
                                  input logic [31:0] av,
                                  input logic [31:0] bv,
                                  output logic [31:0] eh,
                                  output logic [31:0] el,
                                  output int elat);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        eh = 32'h0;
        el = 32'h0;
        elat = 0;
        case (o)
            2'd0: begin
                p = sa * sb;
                eh = p[63:32]; el = p[31:0]; elat = 37;
            end
            2'd1: begin
                p = {32'h0, av} * {32'h0, bv};
                eh = p[63:32]; el = p[31:0]; elat = 33;
            end
            2'd2: begin
                if (bv == 32'h0) begin
                    eh = av; el = 32'hFFFFFFFF; elat = 1;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    eh = r[31:0]; el = q[31:0]; elat = 37;
                end
            end
            default: begin
                if (bv == 32'h0) begin
                    eh = av; el = 32'hFFFFFFFF; elat = 1;
                end else begin
                    eh = av % bv; el = av / bv; elat = 33;
                end
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] eh,
                          input logic [31:0] el, input int elat,
                          input string tag);
        int lat;
        int nbusy;
        bit got;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
        lat = 1; nbusy = 0; got = 0;
        while (lat <= 60) begin
            if (done) begin
                got = 1;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        chk({tag, " done_seen"}, 64'(got), 64'd1);
        if (got) begin
            chk({tag, " latency"}, 64'(lat), 64'(elat));
            chk({tag, " busy_cycles"}, 64'(nbusy), 64'(elat - 1));
            chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
            chk({tag, " hi"}, 64'(hi), 64'(eh));
            chk({tag, " lo"}, 64'(lo), 64'(el));
            @(negedge clk);
            chk({tag, " done_pulse"}, 64'(done), 64'd0);
            chk({tag, " hi_hold"}, 64'(hi), 64'(eh));
            chk({tag, " lo_hold"}, 64'(lo), 64'(el));
        end
    endtask

    initial begin
        logic [31:0] eh, el, ra, rb;
        logic [1:0]  ro;
        logic [31:0] cap_h, cap_l;
        int          elat, ndone, sel;

        vt[0] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
        vt[1] = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 37};
        vt[2] = '{2'd0, 32'h00000000, 32'hFFFFFFFB, 32'h00000000, 32'h00000000, 37};
        vt[3] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 37};
        vt[4] = '{2'd3, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'h00000001, 33};
        vt[5] = '{2'd3, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1};
        vt[6] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 37};
        vt[7] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 37};
        vt[8] = '{2'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1};

        rst_n = 1'b0; start = 1'b0; op = 2'd0; a = 32'h0; b = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("idle alu_op", 64'(alu_op), 64'd2);
        chk("idle alu_a", 64'(alu_a), 64'd0);
        chk("idle alu_b", 64'(alu_b), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo,
                   vt[i].lat, $sformatf("vec%0d", i));
        end

        // start held high every cycle of a MULTU with changing operands
        @(negedge clk);
        start = 1'b1; op = 2'd1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        ndone = 0; cap_h = 32'h0; cap_l = 32'h0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            op = 2'($urandom); a = $urandom; b = $urandom;
            if (done) begin
                ndone++;
                cap_h = hi; cap_l = lo;
            end
        end
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 45; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("spam done_count", 64'(ndone), 64'd1);
        chk("spam hi", 64'(cap_h), 64'hFFFFFFFE);
        chk("spam lo", 64'(cap_l), 64'h00000001);
        chk("spam busy_after", 64'(busy), 64'd0);
        chk("spam lo_hold", 64'(lo), 64'h00000001);

        // reset during iteration 10 of a DIV
        @(negedge clk);
        start = 1'b1; op = 2'd2; a = 32'hFFFFFFF9; b = 32'h00000002;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("pre_rst busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst hi", 64'(hi), 64'd0);
        chk("mid_rst lo", 64'(lo), 64'd0);
        chk("mid_rst busy", 64'(busy), 64'd0);
        chk("mid_rst done", 64'(done), 64'd0);
        chk("mid_rst alu_op", 64'(alu_op), 64'd2);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 50; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("post_rst no_done", 64'(ndone), 64'd0);
        run_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 33, "divu100_7");

        for (int n = 0; n < 60; n++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: rb = 32'h0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'h1;
                3: ra = 32'h0;
                4: rb = rb >> $urandom_range(0, 31);
                default: ;
            endcase
            model(ro, ra, rb, eh, el, elat);
            run_op(ro, ra, rb, eh, el, elat, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller that executes MIPS MULT/MULTU/DIV/DIVU by sequencing the 32-bit ALU one iteration per cycle.
- Drives the ALU's op/a/b inputs and consumes its result.
- Writes the 64-bit product, or quotient/remainder, into HI/LO working registers.
- Sits beside the main ALU in the execute stage. The core stalls on busy and samples hi/lo on done.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported; the iteration count equals WIDTH.
- DIV0_LO, 32'hFFFFFFFF, value written to lo on divide-by-zero.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- a  input  32  rs operand (multiplicand / dividend).
- b  input  32  rt operand (multiplier / divisor).
- busy  output  1  high from the cycle after accept until done.
- done  output  1  one-cycle pulse; hi/lo are valid in this cycle.
- hi  output  32  HI register (product[63:32] / remainder).
- lo  output  32  LO register (product[31:0] / quotient).
- alu_op  output  4  ALU opcode: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 XOR.
- alu_a  output  32  ALU operand a.
- alu_b  output  32  ALU operand b.
- alu_result  input  32  combinational ALU result for the current alu_op/a/b.

Behaviour:
- Reset: while rst_n is low, state=IDLE; busy=0, done=0, hi=0, lo=0; all internal registers 0.
- Reset mid-operation aborts immediately. No done is produced.
- Idle cycles: alu_op=2 (ADD), alu_a=0, alu_b=0.
- States: IDLE -> [NEG_A -> NEG_B] -> ITER (32 cycles) -> [FIX_LO -> FIX_HI] -> DONE -> IDLE.
- Bracketed states are entered only for the signed ops (MULT, DIV).
- Accept: in IDLE with start=1, latch op/a/b and clear the iteration counter.
  - hi<=0; lo<=a for DIV/DIVU, lo<=b for MULT/MULTU.
  - Record neg_a=a[31] and neg_b=b[31] (signed ops only; 0 otherwise).
- start while busy or in DONE is ignored (not queued).
- NEG_A (1 cycle): ALU SUB 0-a; the result replaces the working dividend/multiplicand if neg_a.
- NEG_B (1 cycle): ALU SUB 0-b; the result replaces the working multiplier/divisor if neg_b.
- Divide-by-zero (divisor==0 after accept): skip ITER and FIX. Go directly to DONE with hi=a (original), lo=DIV0_LO.
  - Latency: done 1 cycle after accept.
- ITER multiply (per cycle):
  - alu_op=ADD, alu_a=hi, alu_b = lo[0] ? mcand : 0.
  - carry = (alu_result < hi), unsigned local compare.
  - {hi,lo} <= {carry, alu_result, lo[31:1]}, i.e. a 65-bit right shift.
- ITER divide (per cycle):
  - sh = {hi[30:0], lo[31]}; alu_op=SUB, alu_a=sh, alu_b=divisor.
  - If hi[31]==1 or sh >= divisor (unsigned): hi<=alu_result, qbit=1.
  - Else: hi<=sh, qbit=0.
  - lo <= {lo[30:0], qbit}.
  - The hi[31] term covers divisors above 2^31.
- FIX_LO (1 cycle): ALU SUB 0-lo.
  - MULT: apply if neg_a^neg_b.
  - DIV: apply if neg_a^neg_b, negating the quotient.
  - Latch lo_zero = (pre-fix lo==0).
- FIX_HI (1 cycle): ALU SUB 0-hi.
  - DIV: hi<=result if neg_a (remainder takes the dividend's sign).
  - MULT with sign flip: hi <= lo_zero ? result : ~hi (64-bit two's-complement negate).
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- hi/lo hold their values until the next accept. Intermediate hi/lo values during busy are not architecturally valid.
- Latency from the accept edge to done high:
  - unsigned: 33 cycles;
  - signed: 37 cycles;
  - divide-by-zero: 1 cycle.
- Earliest next accept: the cycle after done.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done 33 cycles after accept, hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1..32.
- MULT a=0xFFFFFFFD (-3) b=7 -> done at cycle 37, hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT a=0 b=-5 -> hi=0, lo=0, which exercises lo_zero.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=0xFFFFFFFF b=0x80000001 -> lo=1, hi=0x7FFFFFFE.
- DIVU a=0x1234 b=0 -> done 1 cycle after accept, hi=0x1234, lo=0xFFFFFFFF.
- Assert start with a new op every cycle during a MULTU -> ignored; the result matches the first op, and exactly one done pulse.
- Drop rst_n at iteration 10 of a DIV -> hi=lo=0, busy=0, no done. A following DIVU 100/7 -> lo=14, hi=2.
